// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NREQ requesters.
// Sequences full writes, reads and read-modify-write for partial byte-enable writes.
module mem_port_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ-1:0]      req_we_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*32-1:0]   req_wdata_i,
    input  logic [NREQ*4-1:0]    req_be_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [31:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_q_i
);

    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned ADW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_WAIT, S_WR, S_MRG_WR, S_RESP
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_gnt;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [ADW-1:0]     r_addr;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_mem_we;
    logic [31:0]        r_mem_data;

    logic               w_found;
    logic [PW-1:0]      w_gnt;
    logic [PW:0]        w_k;
    logic [AW-1:0]      w_addr;
    logic               w_we;
    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic               w_oor;
    logic [31:0]        w_merged;
    logic [NREQ-1:0]    w_gnt_oh;
    logic [NREQ-1:0]    w_own_oh;
    logic [PW-1:0]      w_ptr_nxt;

    // Scan from r_ptr upward (wrapping); the lowest offset with valid wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_k     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_k = (PW+1)'(r_ptr) + (PW+1)'(i);
            if (w_k >= (PW+1)'(NREQ)) begin
                w_k = w_k - (PW+1)'(NREQ);
            end
            if (req_valid_i[w_k[PW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_k[PW-1:0];
            end
        end
    end

    assign w_addr  = req_addr_i[int'(w_gnt) * AW +: AW];
    assign w_we    = req_we_i[w_gnt];
    assign w_wdata = req_wdata_i[int'(w_gnt) * 32 +: 32];
    assign w_be    = req_be_i[int'(w_gnt) * 4 +: 4];
    assign w_oor   = 64'(w_addr) >= 64'(DEPTH);

    assign w_gnt_oh  = NREQ'(1'b1) << w_gnt;
    assign w_own_oh  = NREQ'(1'b1) << r_gnt;
    assign w_ptr_nxt = (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);

    always_comb begin
        w_merged = '0;
        for (int k = 0; k < 4; k++) begin
            w_merged[8*k +: 8] = r_be[k] ? r_wdata[8*k +: 8] : mem_q_i[8*k +: 8];
        end
    end

    // Ready is gated by reset so nothing is accepted while rst_n_i is low.
    assign req_ready_o = (r_state == S_IDLE && w_found && rst_n_i) ? w_gnt_oh : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_addr      <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_data  <= '0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_data  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt;
                        r_we    <= w_we;
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_addr  <= w_addr[ADW-1:0];
                        if (w_oor) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= w_gnt_oh;
                            r_rsp_err   <= 1'b1;
                        end else if (w_we && w_be == 4'h0) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= w_gnt_oh;
                        end else if (w_we && w_be == 4'hF) begin
                            r_state    <= S_WR;
                            r_mem_we   <= 1'b1;
                            r_mem_data <= w_wdata;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= w_own_oh;
                end
                S_RD: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_we) begin
                        r_state    <= S_MRG_WR;
                        r_mem_we   <= 1'b1;
                        r_mem_data <= w_merged;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= w_own_oh;
                        r_rsp_rdata <= mem_q_i;
                    end
                end
                S_MRG_WR: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= w_own_oh;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ptr   <= w_ptr_nxt;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = 32'(r_addr);
    assign mem_data_o  = r_mem_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions,
// then contention, reset-in-flight and release sequences against a behavioural RAM.
module tb_mem_port_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 256;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*32-1:0]   req_wdata;
    logic [NREQ*4-1:0]    req_be;
    logic [NREQ-1:0]      rsp_valid_o;
    logic [31:0]          rsp_rdata_o;
    logic                 rsp_err_o;
    logic                 mem_we_o;
    logic [31:0]          mem_addr_o;
    logic [31:0]          mem_data_o;
    logic [31:0]          mem_q_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_q_i     (mem_q_i)
    );

    // Behavioural single-port RAM with registered address.
    logic [31:0] ram [0:255];
    logic [7:0]  ram_a;
    logic        ram_clr;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        end else if (mem_we_o) begin
            ram[mem_addr_o[7:0]] <= mem_data_o;
        end
        ram_a <= mem_addr_o[7:0];
    end
    assign mem_q_i = ram[ram_a];

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          nwe;
        logic [31:0] wedata;
        int          welat;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output int lat, output logic [NREQ-1:0] vb,
                           output logic [31:0] rd, output logic er, output int nwe,
                           output logic [31:0] wd, output logic [31:0] wa,
                           output int welat);
        bit got;
        bit done;
        lat = 0; vb = '0; rd = '0; er = 1'b0; nwe = 0; wd = '0; wa = '0; welat = 0;
        @(posedge clk); #1;
        req_we[idx]              = we;
        req_addr[idx*AW +: AW]   = addr;
        req_wdata[idx*32 +: 32]  = wdata;
        req_be[idx*4 +: 4]       = be;
        req_valid[idx]           = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready_o[idx]) got = 1'b1;
        end
        chk($sformatf("accept req%0d", idx), 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        done = 1'b0;
        for (int n = 1; n <= 10 && !done; n++) begin
            @(negedge clk);
            if (mem_we_o) begin
                nwe++;
                wd    = mem_data_o;
                wa    = mem_addr_o;
                welat = n;
            end
            if (rsp_valid_o != '0) begin
                lat  = n;
                vb   = rsp_valid_o;
                rd   = rsp_rdata_o;
                er   = rsp_err_o;
                done = 1'b1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               lat, nwe, welat, g;
        logic [NREQ-1:0]  vb;
        logic [31:0]      rd, wd, wa;
        logic             er;
        bit               got, done;

        vt[0]  = '{0, 1'b1, 32'd5,   32'h12345678, 4'hF, 2, 32'h0,        1'b0, 1, 32'h12345678, 1};
        vt[1]  = '{0, 1'b0, 32'd5,   32'h0,        4'h0, 3, 32'h12345678, 1'b0, 0, 32'h0,        0};
        vt[2]  = '{1, 1'b1, 32'd5,   32'hAABBCCDD, 4'h5, 4, 32'h0,        1'b0, 1, 32'h12BB56DD, 3};
        vt[3]  = '{1, 1'b0, 32'd5,   32'h0,        4'h0, 3, 32'h12BB56DD, 1'b0, 0, 32'h0,        0};
        vt[4]  = '{0, 1'b1, 32'd256, 32'hFFFFFFFF, 4'hF, 1, 32'h0,        1'b1, 0, 32'h0,        0};
        vt[5]  = '{1, 1'b1, 32'd7,   32'hFFFFFFFF, 4'h0, 1, 32'h0,        1'b0, 0, 32'h0,        0};
        vt[6]  = '{0, 1'b0, 32'd7,   32'h0,        4'h0, 3, 32'h0,        1'b0, 0, 32'h0,        0};
        vt[7]  = '{1, 1'b0, 32'd300, 32'h0,        4'h0, 1, 32'h0,        1'b1, 0, 32'h0,        0};
        vt[8]  = '{1, 1'b1, 32'd255, 32'hA5A5A5A5, 4'h8, 4, 32'h0,        1'b0, 1, 32'hA5000000, 3};
        vt[9]  = '{0, 1'b0, 32'd255, 32'h0,        4'h0, 3, 32'hA5000000, 1'b0, 0, 32'h0,        0};
        vt[10] = '{0, 1'b0, 32'd0,   32'h0,        4'h0, 3, 32'h0,        1'b0, 0, 32'h0,        0};
        vt[11] = '{0, 1'b1, 32'd1,   32'h11111111, 4'hF, 2, 32'h0,        1'b0, 1, 32'h11111111, 1};
        vt[12] = '{1, 1'b1, 32'd2,   32'h22222222, 4'hF, 2, 32'h0,        1'b0, 1, 32'h22222222, 1};
        vt[13] = '{1, 1'b0, 32'd2,   32'h0,        4'h0, 3, 32'h22222222, 1'b0, 0, 32'h0,        0};

        // Reset with requests pending: nothing may be accepted or driven.
        rst_n = 1'b0; ram_clr = 1'b1;
        req_valid = '1; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        #2;
        chk("reset ready", 32'(req_ready_o), 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset mem_we", 32'(mem_we_o), 32'h0);
        chk("reset mem_addr", mem_addr_o, 32'h0);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1; ram_clr = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_txn(vt[i].idx, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be,
                    lat, vb, rd, er, nwe, wd, wa, welat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d rsp owner", i), 32'(vb), 32'(1 << vt[i].idx));
            chk($sformatf("v%0d rdata", i), rd, vt[i].rdata);
            chk($sformatf("v%0d err", i), 32'(er), 32'(vt[i].err));
            chk($sformatf("v%0d we count", i), 32'(nwe), 32'(vt[i].nwe));
            if (vt[i].nwe > 0) begin
                chk($sformatf("v%0d we data", i), wd, vt[i].wedata);
                chk($sformatf("v%0d we addr", i), wa, vt[i].addr);
                chk($sformatf("v%0d we cycle", i), 32'(welat), 32'(vt[i].welat));
            end
        end

        // Contention: both requesters valid continuously; pointer is 0 here.
        @(posedge clk); #1;
        req_we = '0; req_be = '0;
        req_addr[0 +: AW]  = 32'd1;
        req_addr[AW +: AW] = 32'd2;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = -1;
            for (int n = 0; n < 20 && g < 0; n++) begin
                @(negedge clk);
                if (req_ready_o == 2'b01) g = 0;
                else if (req_ready_o == 2'b10) g = 1;
            end
            chk($sformatf("cont grant %0d", k), 32'(g), 32'(k % 2));
            if (k == 3) begin
                @(posedge clk); #1;
                req_valid = '0;
            end
            done = 1'b0;
            for (int n = 0; n < 10 && !done; n++) begin
                @(negedge clk);
                if (rsp_valid_o != '0) begin
                    done = 1'b1;
                    chk($sformatf("cont owner %0d", k), 32'(rsp_valid_o), 32'(1 << (k % 2)));
                    chk($sformatf("cont rdata %0d", k), rsp_rdata_o,
                        (k % 2) ? 32'h22222222 : 32'h11111111);
                end
            end
            chk($sformatf("cont rsp seen %0d", k), 32'(done), 32'd1);
        end

        // Move the pointer to 1, then reset in the middle of a read by req1.
        run_txn(0, 1'b0, 32'd1, 32'h0, 4'h0, lat, vb, rd, er, nwe, wd, wa, welat);
        chk("pre-reset read", rd, 32'h11111111);
        @(posedge clk); #1;
        req_addr[AW +: AW] = 32'd2;
        req_we = '0;
        req_valid = 2'b10;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready_o[1]) got = 1'b1;
        end
        chk("inflight accept", 32'(got), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_addr[0 +: AW] = 32'd1;
        req_valid = 2'b11;
        #1;
        chk("midreset ready", 32'(req_ready_o), 32'h0);
        chk("midreset rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("midreset mem_addr", mem_addr_o, 32'h0);
        chk("midreset mem_we", 32'(mem_we_o), 32'h0);
        chk("midreset mem_data", mem_data_o, 32'h0);
        @(posedge clk); #1;
        chk("held reset rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("held reset rdata", rsp_rdata_o, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release first grant", 32'(req_ready_o), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        done = 1'b0; lat = 0;
        for (int n = 1; n <= 10 && !done; n++) begin
            @(negedge clk);
            if (rsp_valid_o != '0) begin
                done = 1'b1;
                lat = n;
                chk("release rsp owner", 32'(rsp_valid_o), 32'h1);
                chk("release rdata", rsp_rdata_o, 32'h11111111);
            end
        end
        chk("release latency", 32'(lat), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
